// File: rtl/board_vga_renderer_if.sv
// Board/cursor input bus from the game manager and VGA output pins of the
// board renderer, bundled so the renderer and its surroundings share one port.
interface board_vga_renderer_if;
  logic [49:0] board;
  logic [2:0]  cursor_row;
  logic [2:0]  cursor_col;
  logic        hsync;
  logic        vsync;
  logic [2:0]  red;
  logic [2:0]  green;
  logic [2:0]  blue;
  logic        frame_start;

  // Board writer / display side
  modport master (
    output board, cursor_row, cursor_col,
    input  hsync, vsync, red, green, blue, frame_start
  );

  // Renderer side
  modport slave (
    input  board, cursor_row, cursor_col,
    output hsync, vsync, red, green, blue, frame_start
  );
endinterface

// File: rtl/board_vga_renderer.sv
// VGA renderer for the 5x5 game board. Generates 640x480@60 timing from a
// prescaled master clock, tracks the current board cell with counters (no
// dividers) and paints grid, cursor border, player markers and cell interiors.
// Board and cursor are snapshotted once per frame at vblank start so the
// picture never tears. Timing totals are parameters so a reduced geometry can
// be used; the defaults are the standard 640x480 mode.
module board_vga_renderer #(
  parameter int CLK_DIV      = 4,
  parameter int BOARD_X0     = 120,
  parameter int BOARD_Y0     = 40,
  parameter int CELL         = 80,
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int H_TOTAL      = 800,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int V_TOTAL      = 525
) (
  input logic clk,
  input logic rst_n,
  board_vga_renderer_if.slave bus
);

  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int OW      = $clog2(CELL);
  localparam int MARK_LO = CELL / 5;
  localparam int MARK_HI = CELL - CELL / 5 - 1;

  // Index value meaning "not inside the board"; 5 is reached after the last cell.
  localparam logic [2:0] IDX_OUT  = 3'd7;
  localparam logic [2:0] IDX_LAST = 3'd4;

  logic [PW-1:0] prescale;
  logic          tick;
  logic [HW-1:0] hCnt, hNext;
  logic [VW-1:0] vCnt, vNext;
  logic          lineEnd, frameEnd;
  logic [2:0]    colIdx, rowIdx;
  logic [OW-1:0] xOff, yOff;
  logic [49:0]   snapBoard;
  logic [2:0]    snapRow, snapCol;
  logic          snapTick;
  logic          hsyncQ, vsyncQ, frameStartQ;
  logic [8:0]    rgbQ, rgbNext;

  assign tick     = (prescale == PW'(CLK_DIV - 1));
  assign lineEnd  = (hCnt == HW'(H_TOTAL - 1));
  assign frameEnd = (vCnt == VW'(V_TOTAL - 1));
  assign hNext    = lineEnd  ? '0 : hCnt + 1'b1;
  assign vNext    = frameEnd ? '0 : vCnt + 1'b1;
  assign snapTick = tick && (hCnt == '0) && (vCnt == VW'(V_VISIBLE));

  // Pixel-rate prescaler: tick is high for one clk every CLK_DIV clks.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)    prescale <= '0;
    else if (tick) prescale <= '0;
    else           prescale <= prescale + 1'b1;
  end

  // Raster position counters, advanced once per pixel tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (tick) begin
      hCnt <= hNext;
      if (lineEnd) vCnt <= vNext;
    end
  end

  // Column index and x offset within the cell, restarted at the board's left edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colIdx <= (BOARD_X0 == 0) ? 3'd0 : IDX_OUT;
      xOff   <= '0;
    end else if (tick) begin
      if (hNext == HW'(BOARD_X0)) begin
        colIdx <= 3'd0;
        xOff   <= '0;
      end else if (colIdx < 3'd5) begin
        if (xOff == OW'(CELL - 1)) begin
          xOff   <= '0;
          colIdx <= colIdx + 3'd1;
        end else begin
          xOff <= xOff + 1'b1;
        end
      end
    end
  end

  // Row index and y offset within the cell, advanced once per line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rowIdx <= (BOARD_Y0 == 0) ? 3'd0 : IDX_OUT;
      yOff   <= '0;
    end else if (tick && lineEnd) begin
      if (vNext == VW'(BOARD_Y0)) begin
        rowIdx <= 3'd0;
        yOff   <= '0;
      end else if (rowIdx < 3'd5) begin
        if (yOff == OW'(CELL - 1)) begin
          yOff   <= '0;
          rowIdx <= rowIdx + 3'd1;
        end else begin
          yOff <= yOff + 1'b1;
        end
      end
    end
  end

  // Once-per-frame snapshot of board and cursor, plus the frame_start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the snapshot is a handful of flops, so it is reset to a known empty board.
    if (!rst_n) begin
      snapBoard   <= '0;
      snapRow     <= IDX_OUT;
      snapCol     <= IDX_OUT;
      frameStartQ <= 1'b0;
    end else begin
      frameStartQ <= snapTick;
      if (snapTick) begin
        snapBoard <= bus.board;
        snapRow   <= bus.cursor_row;
        snapCol   <= bus.cursor_col;
      end
    end
  end

  logic       visible, inBoard, cursorHere;
  logic       xGrid, yGrid, xBand, yBand, xMark, yMark;
  logic [4:0] cellIdx;
  logic [1:0] cellVal;

  assign visible    = (hCnt < HW'(H_VISIBLE)) && (vCnt < VW'(V_VISIBLE));
  assign inBoard    = (colIdx < 3'd5) && (rowIdx < 3'd5);
  assign xGrid      = (xOff < OW'(2)) || ((colIdx == IDX_LAST) && (xOff >= OW'(CELL - 2)));
  assign yGrid      = (yOff < OW'(2)) || ((rowIdx == IDX_LAST) && (yOff >= OW'(CELL - 2)));
  assign xBand      = ((xOff >= OW'(2)) && (xOff <= OW'(5))) ||
                      ((xOff >= OW'(CELL - 6)) && (xOff <= OW'(CELL - 3)));
  assign yBand      = ((yOff >= OW'(2)) && (yOff <= OW'(5))) ||
                      ((yOff >= OW'(CELL - 6)) && (yOff <= OW'(CELL - 3)));
  assign xMark      = (xOff >= OW'(MARK_LO)) && (xOff <= OW'(MARK_HI));
  assign yMark      = (yOff >= OW'(MARK_LO)) && (yOff <= OW'(MARK_HI));
  assign cursorHere = (snapRow <= IDX_LAST) && (snapCol <= IDX_LAST) &&
                      (snapRow == rowIdx) && (snapCol == colIdx);
  assign cellIdx    = 5'(rowIdx) * 5'd5 + 5'(colIdx);

  // Select the snapshot cell under the beam with constant part-selects.
  always_comb begin
    // NOTE: default first so no path leaves cellVal unassigned (no latch).
    cellVal = 2'd0;
    for (int i = 0; i < 25; i++) begin
      if (cellIdx == 5'(i)) cellVal = snapBoard[2*i +: 2];
    end
  end

  // Pixel colour with grid > cursor > marker > interior priority.
  always_comb begin
    rgbNext = 9'd0;
    if (visible && inBoard) begin
      if (xGrid || yGrid)                         rgbNext = {3'd7, 3'd7, 3'd7};
      else if (cursorHere && (xBand || yBand))    rgbNext = {3'd7, 3'd7, 3'd0};
      else if (xMark && yMark && cellVal == 2'd1) rgbNext = {3'd7, 3'd0, 3'd0};
      else if (xMark && yMark && cellVal == 2'd2) rgbNext = {3'd0, 3'd0, 3'd7};
      else                                        rgbNext = {3'd1, 3'd1, 3'd1};
    end
  end

  // Registered sync and colour, all updated together on the pixel tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsyncQ <= 1'b1;
      vsyncQ <= 1'b1;
      rgbQ   <= 9'd0;
    end else if (tick) begin
      hsyncQ <= !((hCnt >= HW'(H_SYNC_START)) && (hCnt < HW'(H_SYNC_END)));
      vsyncQ <= !((vCnt >= VW'(V_SYNC_START)) && (vCnt < VW'(V_SYNC_END)));
      rgbQ   <= rgbNext;
    end
  end

  assign bus.hsync       = hsyncQ;
  assign bus.vsync       = vsyncQ;
  assign bus.red         = rgbQ[8:6];
  assign bus.green       = rgbQ[5:3];
  assign bus.blue        = rgbQ[2:0];
  assign bus.frame_start = frameStartQ;

endmodule

// File: tb/tb_board_vga_renderer.sv
// Scoreboard bench for board_vga_renderer on a reduced raster geometry.
// A reference model derives each pixel from its (x,y) position with plain
// division/modulo and pushes the expected outputs every clk; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_board_vga_renderer;

  localparam int CLK_DIV      = 2;
  localparam int BOARD_X0     = 4;
  localparam int BOARD_Y0     = 2;
  localparam int CELL         = 16;
  localparam int H_VISIBLE    = 88;
  localparam int H_SYNC_START = 89;
  localparam int H_SYNC_END   = 93;
  localparam int H_TOTAL      = 96;
  localparam int V_VISIBLE    = 84;
  localparam int V_SYNC_START = 85;
  localparam int V_SYNC_END   = 87;
  localparam int V_TOTAL      = 88;

  localparam int LINE_CLKS  = H_TOTAL * CLK_DIV;
  localparam int FRAME_CLKS = LINE_CLKS * V_TOTAL;
  // First tick lands CLK_DIV clks after release; the snapshot follows
  // V_VISIBLE lines later.
  localparam int FIRST_FS   = V_VISIBLE * LINE_CLKS + CLK_DIV;
  // Clks from a frame_start to the middle of a board cell in the next frame.
  localparam int MID_CLKS   = (((V_TOTAL - V_VISIBLE) + V_VISIBLE / 2) * H_TOTAL
                               + BOARD_X0 + CELL / 2) * CLK_DIV;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [8:0] rgb;
    logic       fs;
  } obs_t;

  typedef struct {
    obs_t o;
    int   x;
    int   y;
  } exp_t;

  localparam obs_t RESET_OBS = '{hs: 1'b1, vs: 1'b1, rgb: 9'd0, fs: 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  board_vga_renderer_if bus();

  board_vga_renderer #(
    .CLK_DIV(CLK_DIV), .BOARD_X0(BOARD_X0), .BOARD_Y0(BOARD_Y0), .CELL(CELL),
    .H_VISIBLE(H_VISIBLE), .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END),
    .H_TOTAL(H_TOTAL), .V_VISIBLE(V_VISIBLE), .V_SYNC_START(V_SYNC_START),
    .V_SYNC_END(V_SYNC_END), .V_TOTAL(V_TOTAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    return {bus.hsync, bus.vsync, bus.red, bus.green, bus.blue, bus.frame_start};
  endfunction

  // ---------------- reference model ----------------
  logic [49:0] mBoard;
  int          mRow, mCol;
  exp_t        expQ[$];
  exp_t        held, item;
  int          edgeCnt, pix, px, py;

  function automatic bit in_band(input int o);
    return ((o >= 2) && (o <= 5)) || ((o >= CELL - 6) && (o <= CELL - 3));
  endfunction

  function automatic logic [8:0] ref_rgb(input int x, input int y);
    int dx, dy, c, r, xo, yo;
    logic [1:0] v;
    bit mark;
    if (x >= H_VISIBLE || y >= V_VISIBLE) return 9'd0;
    dx = x - BOARD_X0;
    dy = y - BOARD_Y0;
    if (dx < 0 || dy < 0 || dx >= 5 * CELL || dy >= 5 * CELL) return 9'd0;
    c  = dx / CELL;
    r  = dy / CELL;
    xo = dx % CELL;
    yo = dy % CELL;
    if (xo < 2 || yo < 2 || (c == 4 && xo >= CELL - 2) || (r == 4 && yo >= CELL - 2))
      return 9'o777;
    if (r == mRow && c == mCol && (in_band(xo) || in_band(yo))) return 9'o770;
    mark = (xo >= CELL / 5) && (xo <= CELL - 1 - CELL / 5) &&
           (yo >= CELL / 5) && (yo <= CELL - 1 - CELL / 5);
    v = mBoard[2 * (5 * r + c) +: 2];
    if (mark && v == 2'd1) return 9'o700;
    if (mark && v == 2'd2) return 9'o007;
    return 9'o111;
  endfunction

  // Model: one expected observation per clk, following pixel ticks by clk count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expQ.delete();
      edgeCnt = 0;
      held    = '{o: RESET_OBS, x: -1, y: -1};
      mBoard  = '0;
      mRow    = 7;
      mCol    = 7;
    end else begin
      edgeCnt++;
      item = held;
      if (edgeCnt % CLK_DIV == 0) begin
        pix  = edgeCnt / CLK_DIV - 1;
        px   = pix % H_TOTAL;
        py   = (pix / H_TOTAL) % V_TOTAL;
        item.x = px;
        item.y = py;
        item.o.hs  = !(px >= H_SYNC_START && px < H_SYNC_END);
        item.o.vs  = !(py >= V_SYNC_START && py < V_SYNC_END);
        item.o.rgb = ref_rgb(px, py);
        held = item;
        if (px == 0 && py == V_VISIBLE) begin
          item.o.fs = 1'b1;
          mBoard = bus.board;
          mRow   = int'(bus.cursor_row);
          mCol   = int'(bus.cursor_col);
        end
      end
      expQ.push_back(item);
    end
  end

  // Monitor: compare DUT outputs on the falling edge.
  exp_t monExp;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", 32'(sample()), 32'(RESET_OBS));
    end else if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      check($sformatf("pixel(%0d,%0d)", monExp.x, monExp.y), 32'(sample()), 32'(monExp.o));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [49:0] rand_board();
    logic [49:0] b;
    for (int i = 0; i < 25; i++) b[2*i +: 2] = 2'($urandom_range(0, 3));
    return b;
  endfunction

  function automatic logic [49:0] with_cell(input logic [49:0] b, input int r,
                                            input int c, input logic [1:0] v);
    logic [49:0] o;
    o = b;
    o[2 * (5 * r + c) +: 2] = v;
    return o;
  endfunction

  task automatic wait_fs(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (bus.frame_start === 1'b1) return;
    end
  endtask

  int cyc;

  initial begin
    bus.board      = '0;
    bus.cursor_row = 3'd7;
    bus.cursor_col = 3'd7;
    repeat (3) @(negedge clk);

    // Frame A: random board with player1 at (2,3), cursor at (0,0).
    bus.board      = with_cell(with_cell(rand_board(), 2, 3, 2'd1), 4, 4, 2'd0);
    bus.cursor_row = 3'd0;
    bus.cursor_col = 3'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_fs(FRAME_CLKS + 100, cyc);
    check("first_frame_start", 32'(cyc), 32'(FIRST_FS));

    // Mid-frame change: must not show until the next snapshot.
    repeat (MID_CLKS) @(negedge clk);
    bus.board      = with_cell(rand_board(), 4, 4, 2'd2);
    bus.cursor_row = 3'd5;
    bus.cursor_col = 3'($urandom_range(0, 4));
    wait_fs(FRAME_CLKS + 100, cyc);
    check("frame_period", 32'(MID_CLKS + cyc), 32'(FRAME_CLKS));

    // Asynchronous reset in the middle of a board cell.
    repeat (MID_CLKS) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset", 32'(sample()), 32'(RESET_OBS));
    bus.board      = rand_board();
    bus.cursor_row = 3'($urandom_range(0, 4));
    bus.cursor_col = 3'($urandom_range(0, 4));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_fs(FRAME_CLKS + 100, cyc);
    check("post_reset_frame_start", 32'(cyc), 32'(FIRST_FS));

    repeat (LINE_CLKS * (V_TOTAL - V_VISIBLE + BOARD_Y0 + 2 * CELL)) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
